ss_sum_feeder: RTL and testbench

//  Producer/sequencer side of the running-sum handshake. Buffers up to DEPTH samples, then on i_go

---
 rtl/ss_pkg.sv | 28 ++
 rtl/ss_sample_buf.sv | 70 +++++++
 rtl/ss_sum_feeder.sv | 237 +++++++++++++++++++++++
 tb/tb_ss_sum_feeder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared types and constants for the running-sum feeder (ss_sum_feeder).
// The frame sequencer walks IDLE -> START -> (FEED -> WAIT)* -> OUT -> CAP -> IDLE.
package ss_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4,
        CAP   = 3'd5
    } feed_state_t;

    // Cycles start is held before the first sample: one for the summer to
    // see the rising edge, one for it to clear its accumulator.
    localparam int unsigned START_CYC = 2;

    // A summer frame is open (start held high) from START through OUT.
    function automatic logic frame_open(input feed_state_t s);
        logic open_v;
        case (s)
            START, FEED, WAIT, OUT: open_v = 1'b1;
            default:                open_v = 1'b0;
        endcase
        return open_v;
    endfunction

endpackage

// File: rtl/ss_sample_buf.sv
// Sample buffer for ss_sum_feeder: DEPTH x SIZE_DATA register file filled in
// order from entry 0, with occupancy count, full flag and a random read port.
// A clear empties the buffer (contents are simply overwritten later).
module ss_sample_buf #(
    parameter int SIZE_DATA = 8,
    parameter int DEPTH     = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr_en,
    input  logic [SIZE_DATA-1:0]          i_wr_data,
    input  logic                          i_clr,
    input  logic [$clog2(DEPTH)-1:0]      i_rd_idx,
    output logic [SIZE_DATA-1:0]          o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0]    o_count,
    output logic                          o_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [SIZE_DATA-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [IDX_W-1:0]     wr_ptr_s;
    logic                 full_s;
    logic                 wr_ok_s;

    assign full_s   = (count_q == CNT_W'(DEPTH));
    assign wr_ok_s  = i_wr_en & ~full_s & ~i_clr;
    // Entries fill in order, so the next free slot is the occupancy count.
    assign wr_ptr_s = IDX_W'(count_q);

    // Next occupancy: clear has priority over an append.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (wr_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Occupancy counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Sample storage, written at the current fill position.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok_s) begin
            mem_q[wr_ptr_s] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_idx];
    assign o_count   = count_q;
    assign o_full    = full_s;

endmodule

// File: rtl/ss_sum_feeder.sv
// ss_sum_feeder: producer/sequencer side of the running-sum handshake.
// Buffers samples while idle; on i_go runs one summer frame (start, one
// en_cal per sample paced by i_en_next_value, en_out until i_done) and
// captures the returned sum on o_result with a one-cycle o_result_valid.
// Optional feature macro: SS_FEED_TIMEOUT_EN adds a watchdog on the WAIT and
// OUT states that aborts the frame with an o_err pulse after TIMEOUT_CYC cycles.
module ss_sum_feeder
    import ss_pkg::*;
#(
    parameter int SIZE_DATA   = 8,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [SIZE_DATA-1:0] i_wr_data,
    output logic                 o_full,
    input  logic                 i_go,
    output logic                 o_busy,
    output logic                 o_start_cal_sum,
    output logic                 o_en_cal_sum,
    output logic                 o_en_out_sum,
    output logic [SIZE_DATA-1:0] o_data,
    input  logic                 i_en_next_value,
    input  logic                 i_done,
    input  logic [SIZE_DATA:0]   i_sum,
    output logic [SIZE_DATA:0]   o_result,
    output logic                 o_result_valid,
    output logic                 o_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    feed_state_t          state_q;
    feed_state_t          state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [1:0]           scnt_q;
    logic [1:0]           scnt_d;
    logic [SIZE_DATA:0]   result_q;
    logic [SIZE_DATA:0]   result_d;
    logic                 rv_q;
    logic                 rv_d;
    logic                 err_q;
    logic                 busy_q;
    logic                 start_q;
    logic                 en_cal_q;
    logic                 en_out_q;
    logic [SIZE_DATA-1:0] data_q;
    logic [SIZE_DATA-1:0] data_d;

    logic                 wr_accept_s;
    logic                 buf_clr_s;
    logic [SIZE_DATA-1:0] buf_rd_data_s;
    logic [CNT_W-1:0]     buf_count_s;
    logic                 buf_full_s;
    logic                 last_idx_s;
    logic                 timeout_hit_s;
    logic                 abort_s;

    // Writes land only while idle; the buffer itself drops them when full.
    assign wr_accept_s = i_wr_en & (state_q == IDLE);
    // The buffer empties at the end of every frame, successful or aborted.
    assign buf_clr_s   = (state_q == CAP) | abort_s;
    assign last_idx_s  = (CNT_W'(idx_q) == (buf_count_s - CNT_W'(1)));

    ss_sample_buf #(
        .SIZE_DATA (SIZE_DATA),
        .DEPTH     (DEPTH)
    ) u_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (wr_accept_s),
        .i_wr_data (i_wr_data),
        .i_clr     (buf_clr_s),
        .i_rd_idx  (idx_d),
        .o_rd_data (buf_rd_data_s),
        .o_count   (buf_count_s),
        .o_full    (buf_full_s)
    );

`ifdef SS_FEED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC+1);

    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;

    // Watchdog fires on the last allowed cycle of WAIT/OUT with no summer response.
    assign timeout_hit_s = (wd_q == WD_W'(TIMEOUT_CYC-1)) &&
                           (((state_q == WAIT) && !i_en_next_value) ||
                            ((state_q == OUT)  && !i_done));

    // Watchdog count: cycles spent in the current WAIT/OUT visit.
    always_comb begin
        wd_d = '0;
        if (((state_q == WAIT) || (state_q == OUT)) && (state_d == state_q)) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = '0;
        end
    end

    // Watchdog register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Frame sequencer: next state, sample index, start pacing and result capture.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        scnt_d   = scnt_q;
        result_d = result_q;
        rv_d     = 1'b0;
        abort_s  = 1'b0;
        case (state_q)
            IDLE: begin
                // A write in the same cycle takes precedence over go.
                if (i_go && !i_wr_en) begin
                    if (buf_count_s == '0) begin
                        result_d = '0;
                        rv_d     = 1'b1;
                    end else begin
                        state_d = START;
                        idx_d   = '0;
                        scnt_d  = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (scnt_q == 2'(START_CYC-1)) begin
                    state_d = FEED;
                end else begin
                    scnt_d = scnt_q + 2'd1;
                end
            end
            FEED: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_en_next_value) begin
                    if (last_idx_s) begin
                        state_d = OUT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FEED;
                    end
                end else if (timeout_hit_s) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            OUT: begin
                // Capture on the publish pulse so result and valid update together in CAP.
                if (i_done) begin
                    result_d = i_sum;
                    rv_d     = 1'b1;
                    state_d  = CAP;
                end else if (timeout_hit_s) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            CAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Summer-facing sample: the buffer entry being fed, zero otherwise.
    always_comb begin
        data_d = '0;
        if (state_d == FEED) begin
            data_d = buf_rd_data_s;
        end else begin
            data_d = '0;
        end
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            scnt_q   <= 2'd0;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            en_cal_q <= 1'b0;
            en_out_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            scnt_q   <= scnt_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= abort_s;
            busy_q   <= (state_d != IDLE);
            start_q  <= frame_open(state_d);
            en_cal_q <= (state_d == FEED);
            en_out_q <= (state_d == OUT);
            data_q   <= data_d;
        end
    end

    assign o_full          = buf_full_s;
    assign o_busy          = busy_q;
    assign o_start_cal_sum = start_q;
    assign o_en_cal_sum    = en_cal_q;
    assign o_en_out_sum    = en_out_q;
    assign o_data          = data_q;
    assign o_result        = result_q;
    assign o_result_valid  = rv_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_ss_sum_feeder.sv
// Bench for ss_sum_feeder paired with a behavioural running-sum summer.
// Reference model: a queue of accepted samples; expected result is their
// plain sum modulo 2^(SIZE_DATA+1), expected feed order is queue order.
module tb_ss_sum_feeder;

    localparam int SD    = 8;
    localparam int DP    = 16;
    localparam int TO    = 8;
    localparam int LIMIT = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [SD-1:0] wr_data = '0;
    logic          go = 1'b0;
    logic          o_full, o_busy, o_start, o_en_cal, o_en_out, o_rv, o_err;
    logic [SD-1:0] o_data;
    logic          sm_next, sm_done;
    logic [SD:0]   sm_sum;
    logic [SD:0]   o_result;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ss_sum_feeder #(.SIZE_DATA(SD), .DEPTH(DP), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_full(o_full), .i_go(go), .o_busy(o_busy), .o_start_cal_sum(o_start),
        .o_en_cal_sum(o_en_cal), .o_en_out_sum(o_en_out), .o_data(o_data),
        .i_en_next_value(sm_next), .i_done(sm_done), .i_sum(sm_sum),
        .o_result(o_result), .o_result_valid(o_rv), .o_err(o_err)
    );

    // Behavioural summer: clears on start rising, accumulates on en_cal,
    // acknowledges each sample a cycle later, publishes once per en_out.
    logic [SD:0] acc;
    logic        start_prev;
    bit          block_next = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; start_prev <= 1'b0; sm_next <= 1'b0; sm_done <= 1'b0; sm_sum <= '0;
        end else begin
            start_prev <= o_start;
            if (o_start && !start_prev) acc <= '0;
            else if (o_en_cal) acc <= acc + {1'b0, o_data};
            sm_next <= o_en_cal && !block_next;
            sm_done <= o_en_out && !sm_done;
            if (o_en_out && !sm_done) sm_sum <= acc;
        end
    end

    // Monitor: counts strobes and records fed samples.
    int            mon_encal = 0, mon_rv = 0, mon_rise = 0, mon_bad_data = 0, mon_err = 0;
    logic          mon_prev_start = 1'b0;
    logic [SD-1:0] mon_fed[$];
    always @(negedge clk) begin
        mon_prev_start <= o_start;
        if (o_start && !mon_prev_start) mon_rise <= mon_rise + 1;
        if (o_en_cal) begin
            mon_encal <= mon_encal + 1;
            mon_fed.push_back(o_data);
        end else if (o_data != '0) begin
            mon_bad_data <= mon_bad_data + 1;
        end
        if (o_rv) mon_rv <= mon_rv + 1;
        if (o_err) mon_err <= mon_err + 1;
    end

    logic [SD-1:0] model_q[$];
    logic [SD:0]   last_result = '0;

    task automatic write_sample(input logic [SD-1:0] v);
        wr_en = 1'b1; wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
        if (model_q.size() < DP) model_q.push_back(v);
    endtask

    task automatic run_frame(input string name, input bit stuff);
        int          n_exp, total, cycles, b_encal, b_rv, b_rise, b_fed;
        logic [SD:0] exp_sum;
        bit          fed_ok;
        n_exp = model_q.size();
        total = 0;
        foreach (model_q[i]) total += int'(model_q[i]);
        exp_sum = (SD+1)'(total % (1 << (SD+1)));
        b_encal = mon_encal; b_rv = mon_rv; b_rise = mon_rise; b_fed = mon_fed.size();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cycles = 1;
        while (!o_rv && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
            if (stuff && cycles >= 2 && cycles <= 6) begin
                wr_en = 1'b1; wr_data = SD'($urandom);
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        vec++;
        if (!o_rv) begin
            errs++; $display("FAIL %s timeout: no result_valid after %0d cycles", name, cycles);
        end
        vec++;
        if (o_result !== exp_sum) begin
            errs++; $display("FAIL %s result: got %h expected %h", name, o_result, exp_sum);
        end
        vec++;
        if ((n_exp == 0 && cycles != 1) || cycles > 2*n_exp + 8) begin
            errs++; $display("FAIL %s latency: got %0d cycles for %0d samples", name, cycles, n_exp);
        end
        repeat (3) @(negedge clk);
        vec++;
        if (mon_rv - b_rv !== 1) begin
            errs++; $display("FAIL %s valid_pulses: got %0d expected 1", name, mon_rv - b_rv);
        end
        vec++;
        if (mon_encal - b_encal !== n_exp) begin
            errs++; $display("FAIL %s en_cal_pulses: got %0d expected %0d", name, mon_encal - b_encal, n_exp);
        end
        vec++;
        if (mon_rise - b_rise !== ((n_exp > 0) ? 1 : 0)) begin
            errs++; $display("FAIL %s start_rises: got %0d expected %0d", name, mon_rise - b_rise, (n_exp > 0) ? 1 : 0);
        end
        fed_ok = (mon_fed.size() - b_fed == n_exp);
        for (int i = 0; fed_ok && i < n_exp; i++) begin
            if (mon_fed[b_fed + i] !== model_q[i]) fed_ok = 1'b0;
        end
        vec++;
        if (!fed_ok) begin
            errs++; $display("FAIL %s feed_order: fed %0d samples, order/values differ from %0d buffered", name, mon_fed.size() - b_fed, n_exp);
        end
        vec++;
        if (o_busy !== 1'b0 || o_start !== 1'b0 || o_en_out !== 1'b0) begin
            errs++; $display("FAIL %s idle_after: busy=%b start=%b en_out=%b expected 000", name, o_busy, o_start, o_en_out);
        end
        last_result = exp_sum;
        model_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if ({o_full, o_busy, o_start, o_en_cal, o_en_out, o_rv, o_err} !== 7'b0 ||
            o_data !== '0 || o_result !== '0) begin
            errs++; $display("FAIL reset_outputs: got flags=%b data=%h result=%h expected all 0",
                {o_full, o_busy, o_start, o_en_cal, o_en_out, o_rv, o_err}, o_data, o_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        write_sample(8'd3); write_sample(8'd5); write_sample(8'd7);
        run_frame("basic_3_5_7", 1'b0);
    endtask

    task automatic test_full;
        for (int i = 0; i < DP; i++) write_sample(8'hFF);
        vec++;
        if (o_full !== 1'b1) begin
            errs++; $display("FAIL full_flag: got %b expected 1", o_full);
        end
        write_sample(8'h11);
        vec++;
        if (o_full !== 1'b1 || model_q.size() != DP) begin
            errs++; $display("FAIL full_drop: full=%b model=%0d expected 1/%0d", o_full, model_q.size(), DP);
        end
        run_frame("full_ff", 1'b0);
        vec++;
        if (o_full !== 1'b0) begin
            errs++; $display("FAIL full_cleared: got %b expected 0", o_full);
        end
    endtask

    task automatic test_empty_go;
        run_frame("empty_go", 1'b0);
    endtask

    task automatic test_back_to_back;
        write_sample(8'd1); write_sample(8'd2);
        run_frame("b2b_first", 1'b0);
        write_sample(8'd10);
        run_frame("b2b_second", 1'b0);
    endtask

    task automatic test_busy_drop;
        write_sample(8'd4); write_sample(8'd6); write_sample(8'd8);
        run_frame("busy_drop", 1'b1);
        wr_en = 1'b1; wr_data = 8'd9; go = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; go = 1'b0;
        model_q.push_back(8'd9);
        @(negedge clk);
        vec++;
        if (o_busy !== 1'b0 || o_start !== 1'b0) begin
            errs++; $display("FAIL write_wins: busy=%b start=%b expected 0/0", o_busy, o_start);
        end
        run_frame("after_write_wins", 1'b0);
    endtask

    task automatic test_reset_mid;
        int n;
        for (int i = 0; i < 5; i++) write_sample(SD'(20 + i));
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!o_en_cal && n < 50) begin
            @(negedge clk); n++;
        end
        vec++;
        if (!o_en_cal) begin
            errs++; $display("FAIL reset_mid_feed: no en_cal within %0d cycles", n);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec++;
        if ({o_full, o_busy, o_start, o_en_cal, o_en_out, o_rv, o_err} !== 7'b0 ||
            o_data !== '0 || o_result !== '0) begin
            errs++; $display("FAIL reset_mid_outputs: flags=%b data=%h result=%h expected all 0",
                {o_full, o_busy, o_start, o_en_cal, o_en_out, o_rv, o_err}, o_data, o_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        @(negedge clk);
        write_sample(8'd9); write_sample(8'd1);
        run_frame("after_reset", 1'b0);
    endtask

    task automatic test_random;
        int n;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(DP, 1);
            for (int i = 0; i < n; i++) write_sample(SD'($urandom));
            run_frame($sformatf("random_%0d", f), 1'b0);
        end
    endtask

    task automatic test_data_idle;
        vec++;
        if (mon_bad_data !== 0 || mon_err !== 0) begin
            errs++; $display("FAIL data_zero_idle: nonzero o_data outside feed %0d times, o_err %0d times, expected 0/0", mon_bad_data, mon_err);
        end
    endtask

`ifdef SS_FEED_TIMEOUT_EN
    task automatic test_timeout;
        int cycles, b_rv;
        b_rv = mon_rv;
        block_next = 1'b1;
        write_sample(8'd2); write_sample(8'd3);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cycles = 1;
        while (!o_err && cycles < LIMIT) begin
            @(negedge clk); cycles++;
        end
        vec++;
        // go->START(2)->FEED(1)->WAIT(TO) then the err pulse.
        if (!o_err || cycles != 3 + TO + 1) begin
            errs++; $display("FAIL timeout_err: err=%b at %0d cycles expected 1 at %0d", o_err, cycles, 3 + TO + 1);
        end
        vec++;
        if (o_busy !== 1'b0 || o_start !== 1'b0 || o_result !== last_result || mon_rv != b_rv) begin
            errs++; $display("FAIL timeout_state: busy=%b start=%b result=%h valid_pulses=%0d expected 0/0/%h/0",
                o_busy, o_start, o_result, mon_rv - b_rv, last_result);
        end
        block_next = 1'b0;
        model_q.delete();
        repeat (2) @(negedge clk);
        write_sample(8'd5);
        run_frame("after_timeout", 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_empty_go();
        test_back_to_back();
        test_busy_drop();
        test_reset_mid();
        test_random();
        test_data_idle();
`ifdef SS_FEED_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
